// File: rtl/vector_operand_collect_pkg.sv
// Shared types for the register-read stage: FSM states, instruction encodings
// and the slot-index helper used by both the group picker and the top level.
package vector_operand_collect_pkg;

    localparam int VLEN_DEF = 128;
    localparam int NSLOT    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_LAST  = 2'd2,
        ST_VALID = 2'd3
    } state_t;

    // cur_inst encoding shared with vector_fetch
    typedef enum logic [2:0] {
        INST_VXOR    = 3'd0,
        INST_VADD    = 3'd1,
        INST_VMUL    = 3'd2,
        INST_VREDSUM = 3'd3,
        INST_VLOAD   = 3'd4,
        INST_VSTORE  = 3'd5,
        INST_VSLIDE  = 3'd6,
        INST_INVALID = 3'd7
    } inst_t;

    // Port p of read group grp carries operand slot grp*nrp+p.
    function automatic logic [2:0] slot_of(input int grp, input int port, input int nrp);
        return 3'(grp * nrp + port);
    endfunction

endpackage

// File: rtl/vector_operand_collect_group_pick.sv
// Combinational search for the next read group that has any slot-mask bit set,
// either from group 0 (from_start) or strictly after cur_grp.
module vector_group_pick
    import vector_operand_collect_pkg::*;
#(
    parameter int NRP = 2,
    localparam int G  = NSLOT / NRP,
    localparam int GW = (G > 1) ? $clog2(G) : 1
) (
    input  logic [7:0]    mask,
    input  logic [GW-1:0] cur_grp,
    input  logic          from_start,
    output logic [GW-1:0] nxt_grp,
    output logic          none_left
);

    logic [G-1:0] nonempty;

    always_comb begin
        nonempty = '0;
        for (int g = 0; g < G; g++) begin
            for (int p = 0; p < NRP; p++) begin
                nonempty[g] = nonempty[g] | mask[slot_of(g, p, NRP)];
            end
        end
    end

    // Scan high to low so the lowest qualifying group is the one left standing.
    always_comb begin
        nxt_grp   = '0;
        none_left = 1'b1;
        for (int g = G - 1; g >= 0; g--) begin
            if (nonempty[g] && (from_start || (g > int'(cur_grp)))) begin
                nxt_grp   = GW'(g);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vector_operand_collect.sv
// Register-read stage: gathers up to eight VRF operands through NRP read ports,
// one read group per cycle, and hands them to execute with valid/ready.
module vector_operand_collect
    import vector_operand_collect_pkg::*;
#(
    parameter int VLEN = VLEN_DEF,
    parameter int NRP  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0][4:0]           in_raddr,
    input  logic [7:0]                in_mask,
    input  logic [2:0]                in_inst,
    output logic [NRP-1:0]            rf_ren,
    output logic [NRP-1:0][4:0]       rf_raddr,
    input  logic [NRP-1:0][VLEN-1:0]  rf_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0][VLEN-1:0]      out_opnd,
    output logic [7:0]                out_mask,
    output logic [2:0]                out_inst,
    output logic                      busy
);

    localparam int G  = NSLOT / NRP;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grp_q, grp_d;
    logic [7:0]             mask_q;
    inst_t                  inst_q;
    logic [7:0][4:0]        raddr_q;
    logic [7:0][VLEN-1:0]   slot_q;

    logic                   pend_vld_p1;
    logic [GW-1:0]          pend_grp_p1;
    logic [NRP-1:0]         pend_mask_p1;

    logic                   accept;
    logic                   issue;
    logic [7:0]             pick_mask;
    logic                   pick_from_start;
    logic [GW-1:0]          pick_grp;
    logic                   pick_none;

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_VALID);
    assign busy      = (state_q != ST_IDLE);
    assign out_opnd  = slot_q;
    assign out_mask  = mask_q;
    assign out_inst  = inst_q;

    // In IDLE the picker looks at the incoming mask for the first group;
    // afterwards it walks the latched mask past the current group.
    assign pick_from_start = (state_q == ST_IDLE);
    assign pick_mask       = pick_from_start ? in_mask : mask_q;

    vector_group_pick #(
        .NRP (NRP)
    ) u_pick (
        .mask       (pick_mask),
        .cur_grp    (grp_q),
        .from_start (pick_from_start),
        .nxt_grp    (pick_grp),
        .none_left  (pick_none)
    );

    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        issue    = 1'b0;
        rf_ren   = '0;
        rf_raddr = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (pick_none) begin
                        state_d = ST_VALID;
                    end else begin
                        state_d = ST_ISSUE;
                        grp_d   = pick_grp;
                    end
                end
            end
            ST_ISSUE: begin
                issue = 1'b1;
                for (int p = 0; p < NRP; p++) begin
                    rf_ren[p]   = mask_q[slot_of(int'(grp_q), p, NRP)];
                    rf_raddr[p] = mask_q[slot_of(int'(grp_q), p, NRP)]
                                ? raddr_q[slot_of(int'(grp_q), p, NRP)] : 5'd0;
                end
                if (pick_none) begin
                    state_d = ST_LAST;
                end else begin
                    grp_d = pick_grp;
                end
            end
            ST_LAST: begin
                state_d = ST_VALID;
            end
            ST_VALID: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stage p1: group and port mask of the read issued last cycle, aligned
    // with the returning rf_rdata.
    always_ff @(posedge clk) begin
        if (accept) begin
            raddr_q <= in_raddr;
        end
        if (issue) begin
            pend_grp_p1  <= grp_q;
            pend_mask_p1 <= rf_ren;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grp_q       <= '0;
            pend_vld_p1 <= 1'b0;
            mask_q      <= '0;
            inst_q      <= INST_VXOR;
            slot_q      <= '0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            pend_vld_p1 <= issue;
            if (accept) begin
                mask_q <= in_mask;
                inst_q <= inst_t'(in_inst);
                slot_q <= '0;
            end else if (pend_vld_p1) begin
                for (int p = 0; p < NRP; p++) begin
                    if (pend_mask_p1[p]) begin
                        slot_q[slot_of(int'(pend_grp_p1), p, NRP)] <= rf_rdata[p];
                    end
                end
            end
        end
    end

endmodule
